// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run controller: FSM states (also the debug state
// output) and the run-mode field latched on start.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_HOLD = 3'd1,
    RUN        = 3'd2,
    PAUSE      = 3'd3,
    STEP       = 3'd4,
    DONE       = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_BOUNDED = 2'b01,
    MODE_STEP    = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // The reserved encoding behaves exactly like bounded mode.
  function automatic logic is_bounded(input mode_e m);
    return (m == MODE_BOUNDED) || (m == MODE_RSVD);
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Saturating core-cycle counter: synchronous clear has priority over enable,
// and the count sticks at all-ones instead of wrapping.
module cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run controller for a single core: holds it in reset after start, then runs it
// free, bounded, or in multicycle single steps, and reports how the run ended.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 48,
  parameter int STEP_CYCLES  = 5,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic             halt_in,
  output logic             core_reset,
  output logic             core_clk_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [2:0]       state
);

  localparam int PH_MAX = (RESET_CYCLES > STEP_CYCLES) ? RESET_CYCLES : STEP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int LW     = (CNT_W > 31) ? CNT_W + 1 : 32;
  localparam logic [LW-1:0]   LIMIT_LAST = LW'(MAX_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0] STEP_LAST  = PH_W'(STEP_CYCLES - 1);

  state_e          state_q, state_d;
  mode_e           mode_q;
  logic [PH_W-1:0] phase_q;
  logic            count_clr, count_en, latch_mode, set_halt, set_timeout;
  logic            at_limit;

  // The counter shows the cycles already run, so this is the cycle that reaches the limit.
  assign at_limit = LW'(cycle_count) >= LIMIT_LAST;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    count_clr   = 1'b0;
    count_en    = 1'b0;
    latch_mode  = 1'b0;
    set_halt    = 1'b0;
    set_timeout = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RESET_HOLD;
          latch_mode = 1'b1;
          count_clr  = 1'b1;
        end
      end
      RESET_HOLD: begin
        if (phase_q == HOLD_LAST) state_d = (mode_q == MODE_STEP) ? PAUSE : RUN;
      end
      RUN: begin
        count_en = 1'b1;
        if (halt_in) begin
          state_d  = DONE;
          set_halt = 1'b1;
        end else if (is_bounded(mode_q) && at_limit) begin
          state_d     = DONE;
          set_timeout = 1'b1;
        end
      end
      PAUSE: begin
        if (step_req) state_d = STEP;
      end
      STEP: begin
        count_en = 1'b1;
        if (halt_in) begin
          state_d  = DONE;
          set_halt = 1'b1;
        end else if (phase_q == STEP_LAST) begin
          state_d = PAUSE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything else, including a start in the same cycle.
    if (abort) begin
      state_d     = IDLE;
      count_clr   = 1'b1;
      count_en    = 1'b0;
      latch_mode  = 1'b0;
      set_halt    = 1'b0;
      set_timeout = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_FREE;
      phase_q <= '0;
      halted  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_mode) mode_q <= mode_e'(mode);
      // Phase restarts on every state change, so each hold/step window starts at zero.
      if (state_d != state_q) begin
        phase_q <= '0;
      end else if ((state_q == RESET_HOLD) || (state_q == STEP)) begin
        phase_q <= phase_q + 1'b1;
      end
      if (count_clr) begin
        halted  <= 1'b0;
        timeout <= 1'b0;
      end else if (set_halt) begin
        halted <= 1'b1;
      end else if (set_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

  cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cycle_counter (
    .clock (clock),
    .reset (reset),
    .clear (count_clr),
    .enable(count_en),
    .count (cycle_count)
  );

  always_comb begin
    core_reset  = 1'b0;
    core_clk_en = 1'b0;
    unique case (state_q)
      IDLE:            core_reset  = 1'b1;
      RESET_HOLD: begin
        core_reset  = 1'b1;
        core_clk_en = 1'b1;
      end
      RUN, STEP:       core_clk_en = 1'b1;
      default:         ;
    endcase
  end

  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Randomized bench for run_controller: each run's outcome (count, flags, enabled
// cycles) is predicted from the run rules and compared against the design.
module tb_run_controller;
  import run_ctrl_pkg::*;

  localparam int MAXC  = 48;
  localparam int STEPC = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, abort, step_req, halt_in;
  logic [1:0]  mode;
  logic        core_reset, core_clk_en, done, halted, timeout;
  logic [31:0] cycle_count;
  logic [2:0]  state;

  logic        start2;
  logic [1:0]  mode2;
  logic        c2_core_reset, c2_core_clk_en, c2_done, c2_halted, c2_timeout;
  logic [3:0]  c2_count;
  logic [2:0]  c2_state;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt   = 0;

  always #5 clock = ~clock;

  run_controller dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .step_req   (step_req),
    .halt_in    (halt_in),
    .core_reset (core_reset),
    .core_clk_en(core_clk_en),
    .cycle_count(cycle_count),
    .done       (done),
    .halted     (halted),
    .timeout    (timeout),
    .state      (state)
  );

  run_controller #(.CNT_W(4)) dut_narrow (
    .clock      (clock),
    .reset      (reset),
    .start      (start2),
    .abort      (1'b0),
    .mode       (mode2),
    .step_req   (1'b0),
    .halt_in    (1'b0),
    .core_reset (c2_core_reset),
    .core_clk_en(c2_core_clk_en),
    .cycle_count(c2_count),
    .done       (c2_done),
    .halted     (c2_halted),
    .timeout    (c2_timeout),
    .state      (c2_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Outputs are a function of state only, so the pre-edge view tells whether
  // the coming cycle is a counted core cycle.
  task automatic tick();
    if (core_clk_en && !core_reset) en_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, state, IDLE);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_clk_en"}, core_clk_en, 0);
    check({tag, "_count"}, cycle_count, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic start_run(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    tick();
    start  = 1'b0;
    mode   = 2'($urandom);
    en_cnt = 0;
    check("hold_core_reset", core_reset, 1);
    check("hold_count_zero", cycle_count, 0);
    check("hold_flags_clear", {halted, timeout, done}, 0);
    tick();
    check("hold_released", core_reset, 0);
  endtask

  // Free-run or bounded run; halt_at is the 1-based run cycle carrying halt_in (0 = never).
  task automatic run_to_done(input logic [1:0] m, input int halt_at, input bit noise);
    bit bnd;
    int exp_cnt;
    bit exp_h;
    bnd = (m == MODE_BOUNDED) || (m == MODE_RSVD);
    if (bnd && (halt_at == 0 || halt_at > MAXC)) begin
      exp_cnt = MAXC;
      exp_h   = 1'b0;
    end else begin
      exp_cnt = halt_at;
      exp_h   = 1'b1;
    end
    start_run(m);
    for (int i = 0; i < 200 && !done; i++) begin
      halt_in = (en_cnt + 1 == halt_at);
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        step_req = 1'($urandom_range(0, 1));
      end
      tick();
      halt_in  = 1'b0;
      start    = 1'b0;
      step_req = 1'b0;
    end
    check("run_done", done, 1);
    check("run_count", cycle_count, exp_cnt);
    check("run_halted", halted, exp_h);
    check("run_timeout", timeout, !exp_h);
    check("run_en_cycles", en_cnt, exp_cnt);
    tick();
    check("done_hold_count", cycle_count, exp_cnt);
    check("done_hold_flag", {done, core_clk_en}, 2'b10);
  endtask

  // Single-step run: npulses grants of STEPC cycles; halt_at is the 1-based step cycle
  // carrying halt_in (0 = never). A redundant step_req is always driven inside STEP.
  task automatic step_run(input int npulses, input int halt_at);
    int k;
    int exp_cnt;
    k = 0;
    start_run(MODE_STEP);
    check("step_pause_entry", state, PAUSE);
    for (int p = 0; p < npulses && (k != halt_at || halt_at == 0); p++) begin
      repeat ($urandom_range(0, 2)) tick();
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      for (int s = 0; s < STEPC; s++) begin
        k++;
        halt_in  = (k == halt_at);
        step_req = (s == 2) || 1'($urandom_range(0, 1));
        tick();
        halt_in  = 1'b0;
        step_req = 1'b0;
        if (k == halt_at) break;
      end
    end
    exp_cnt = (halt_at != 0) ? halt_at : npulses * STEPC;
    check("step_count", cycle_count, exp_cnt);
    check("step_en_cycles", en_cnt, exp_cnt);
    if (halt_at != 0) begin
      check("step_halt_done", {done, halted, timeout}, 3'b110);
    end else begin
      check("step_state_pause", state, PAUSE);
      repeat (3) tick();
      check("pause_frozen", cycle_count, exp_cnt);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; step_req = 1'b0; halt_in = 1'b0;
    mode = 2'b00; start2 = 1'b0; mode2 = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    check_idle("reset");
    reset = 1'b0;
    tick();
    check_idle("post_reset");

    run_to_done(MODE_BOUNDED, 0, 1'b0);
    run_to_done(MODE_FREE, 20, 1'b0);
    run_to_done(MODE_BOUNDED, 48, 1'b0);
    run_to_done(MODE_RSVD, 0, 1'b1);
    step_run(3, 0);

    // Abort mid-run, with start asserted alongside it.
    do_abort();
    start_run(MODE_FREE);
    repeat (10) tick();
    check("pre_abort_count", cycle_count, 10);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_idle("abort");

    // Restart from DONE must begin from zero.
    run_to_done(MODE_BOUNDED, 30, 1'b1);
    run_to_done(MODE_FREE, 7, 1'b0);

    // Halt inside a step window.
    do_abort();
    step_run(2, 8);

    // Asynchronous reset between edges in the middle of a STEP window.
    do_abort();
    start_run(MODE_STEP);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    tick();
    check("pre_reset_step", state, STEP);
    #3 reset = 1'b1;
    #1;
    check_idle("async_reset");
    @(posedge clock);
    #2 reset = 1'b0;
    tick();
    check_idle("after_async_reset");

    // Narrow counter saturates in free-run.
    start2 = 1'b1;
    mode2  = MODE_FREE;
    @(posedge clock);
    #1 start2 = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("narrow_saturate", c2_count, 15);
    check("narrow_running", {c2_done, c2_state}, {1'b0, RUN});

    for (int it = 0; it < 12; it++) begin
      int sel;
      sel = $urandom_range(0, 2);
      if (state != IDLE && state != DONE) do_abort();
      if (sel == 0) begin
        run_to_done(MODE_FREE, $urandom_range(1, 60), 1'($urandom_range(0, 1)));
      end else if (sel == 1) begin
        run_to_done(2'($urandom_range(0, 1)) ? MODE_BOUNDED : MODE_RSVD,
                    $urandom_range(0, 60), 1'($urandom_range(0, 1)));
      end else begin
        int np;
        np = $urandom_range(1, 4);
        step_run(np, $urandom_range(0, 1) ? $urandom_range(1, np * STEPC) : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
